// File: rtl/sw_poll_pkg.sv
// Shared types and constants for the slide-switch polling controller.
package sw_poll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2
  } poll_state_e;

  localparam logic [1:0]  PIO_DATA_ADDR    = 2'd0;
  localparam int unsigned PIO_READ_LATENCY = 1;
  localparam int unsigned STABLE_CNT_W     = 4;

endpackage : sw_poll_pkg

// File: rtl/sw_poll_timer.sv
// Free-running poll divider: one-cycle tick every POLL_DIV cycles, first tick POLL_DIV cycles after reset.
module sw_poll_timer #(
  parameter int unsigned POLL_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int unsigned CNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Tick is registered one cycle early so it lands in the cycle where the count reads POLL_DIV-1.
  always_comb begin
    cnt_d  = (cnt_q == CNT_W'(POLL_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
    tick_d = (cnt_q == CNT_W'(POLL_DIV - 2));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule : sw_poll_timer

// File: rtl/sw_poll_ctrl.sv
// Polls the switch PIO over Avalon-MM, debounces the vector and publishes rise/fall events.
// Optional SW_POLL_IRQ_EN adds an irq output and an irq_mask input gating which bits raise events.
module sw_poll_ctrl
  import sw_poll_pkg::*;
#(
  parameter int unsigned SW_WIDTH     = 10,
  parameter int unsigned POLL_DIV     = 50000,
  parameter int unsigned STABLE_COUNT = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic [1:0]          avm_address,
  output logic                avm_read,
  input  logic [31:0]         avm_readdata,
  output logic [SW_WIDTH-1:0] sw_state,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [SW_WIDTH-1:0] evt_rise,
  output logic [SW_WIDTH-1:0] evt_fall,
  output logic                evt_overflow
`ifdef SW_POLL_IRQ_EN
  ,
  output logic                irq,
  input  logic [SW_WIDTH-1:0] irq_mask
`endif
);

  localparam logic [STABLE_CNT_W-1:0] STABLE_MAX = STABLE_CNT_W'(STABLE_COUNT);

  if (PIO_READ_LATENCY != 1) begin : g_latency_check
    $error("sw_poll_ctrl samples readdata exactly one cycle after the read strobe");
  end

  poll_state_e               state_q, state_d;
  logic [SW_WIDTH-1:0]       cand_q, cand_d;
  logic [STABLE_CNT_W-1:0]   stable_q, stable_d;
  logic [SW_WIDTH-1:0]       sw_state_q, sw_state_d;
  logic                      valid_q, valid_d;
  logic [SW_WIDTH-1:0]       rise_q, rise_d;
  logic [SW_WIDTH-1:0]       fall_q, fall_d;
  logic                      ovf_q, ovf_d;
  logic                      read_q, read_d;
  logic [SW_WIDTH-1:0]       sample;
  logic [SW_WIDTH-1:0]       new_rise, new_fall;
  logic                      raise, fire, tick;
  logic                      unused_readdata;

  assign unused_readdata = ^avm_readdata[31:SW_WIDTH];

  sw_poll_timer #(.POLL_DIV(POLL_DIV)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick)
  );

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    stable_d   = stable_q;
    sw_state_d = sw_state_q;
    valid_d    = valid_q;
    rise_d     = rise_q;
    fall_d     = fall_q;
    ovf_d      = ovf_q;
    new_rise   = '0;
    new_fall   = '0;
    raise      = 1'b0;
    sample     = avm_readdata[SW_WIDTH-1:0];
    fire       = valid_q & evt_ready;

    unique case (state_q)
      ST_IDLE:    if (tick) state_d = ST_READ;
      ST_READ:    state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        state_d = ST_IDLE;
        if (sample == cand_q) begin
          if (stable_q != STABLE_MAX) stable_d = stable_q + STABLE_CNT_W'(1);
        end else begin
          cand_d   = sample;
          stable_d = STABLE_CNT_W'(1);
        end
        if ((stable_d == STABLE_MAX) && (cand_d != sw_state_q)) begin
          sw_state_d = cand_d;
          new_rise   = cand_d & ~sw_state_q;
          new_fall   = ~cand_d & sw_state_q;
`ifdef SW_POLL_IRQ_EN
          new_rise   = new_rise & irq_mask;
          new_fall   = new_fall & irq_mask;
`endif
          raise      = |{new_rise, new_fall};
        end
      end
      default:    state_d = ST_IDLE;
    endcase

    // A pending, unaccepted event absorbs the new change and flags the coalescing.
    if (raise) begin
      valid_d = 1'b1;
      if (!valid_q || fire) begin
        rise_d = new_rise;
        fall_d = new_fall;
        ovf_d  = 1'b0;
      end else begin
        rise_d = rise_q | new_rise;
        fall_d = fall_q | new_fall;
        ovf_d  = 1'b1;
      end
    end else if (fire) begin
      valid_d = 1'b0;
      rise_d  = '0;
      fall_d  = '0;
      ovf_d   = 1'b0;
    end

    read_d = (state_d == ST_READ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cand_q     <= '0;
      stable_q   <= '0;
      sw_state_q <= '0;
      valid_q    <= 1'b0;
      rise_q     <= '0;
      fall_q     <= '0;
      ovf_q      <= 1'b0;
      read_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      stable_q   <= stable_d;
      sw_state_q <= sw_state_d;
      valid_q    <= valid_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      ovf_q      <= ovf_d;
      read_q     <= read_d;
    end
  end

`ifdef SW_POLL_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= valid_d;
  end

  assign irq = irq_q;
`endif

  assign avm_address  = PIO_DATA_ADDR;
  assign avm_read     = read_q;
  assign sw_state     = sw_state_q;
  assign evt_valid    = valid_q;
  assign evt_rise     = rise_q;
  assign evt_fall     = fall_q;
  assign evt_overflow = ovf_q;

endmodule : sw_poll_ctrl

// File: doc/sw_poll_ctrl.md
# sw_poll_ctrl

Polling controller for the slide-switch PIO. It periodically issues single-word reads to the PIO data register over an Avalon-MM master port and debounces the returned switch vector. It publishes a stable switch state plus rise/fall change events to downstream game logic through a valid/ready handshake. It sits between the switch PIO slave and the game-state logic, so consumers never touch the raw, bouncing switch inputs.

## Interface
- `SW_WIDTH`, 10: number of switch bits taken from `readdata[SW_WIDTH-1:0]`
- `POLL_DIV`, 50000: clock cycles between poll starts (1 ms at 50 MHz); legal range ≥ 4
- `STABLE_COUNT`, 4: consecutive identical samples required to accept a new value; legal range 1..15
- `clk`  in  1  system clock; the only clock
- `reset`  in  1  reset, synchronous and active-high
- `avm_address`  out  2  PIO register address; always 0 (data register)
- `avm_read`  out  1  read strobe; one cycle per poll
- `avm_readdata`  in  32  PIO read data; fixed read latency of 1 cycle
- `sw_state`  out  SW_WIDTH  debounced switch state
- `evt_valid`  out  1  change event pending
- `evt_ready`  in  1  consumer accepts event
- `evt_rise`  out  SW_WIDTH  bits that went 0→1 since the last accepted event
- `evt_fall`  out  SW_WIDTH  bits that went 1→0 since the last accepted event
- `evt_overflow`  out  1  more than one change was coalesced into the pending event

## Operation
- FSM states: IDLE, READ, CAPTURE.
  - IDLE → READ on a poll tick.
  - READ: `avm_read`=1 and `avm_address`=0 for exactly one cycle; → CAPTURE.
  - CAPTURE: sample `avm_readdata[SW_WIDTH-1:0]`; → IDLE.
- Debounce on each sample `s`:
  - If `s` == candidate: `stable_cnt` increments and saturates at STABLE_COUNT.
  - Otherwise: candidate ← `s` and `stable_cnt` ← 1.
- Acceptance: when `stable_cnt` == STABLE_COUNT after the update and candidate ≠ `sw_state`:
  - `sw_state` ← candidate.
  - `new_rise` = candidate & ~`sw_state`; `new_fall` = ~candidate & `sw_state`.
  - A change event is raised.
- When a change event is raised:
  - No event pending: `evt_valid` ← 1, masks ← new masks, `evt_overflow` ← 0.
  - Event pending and accepted in the same cycle: masks replaced by the new masks, `evt_valid` stays 1, `evt_overflow` ← 0.
  - Event pending and not accepted: masks OR-accumulate with the new masks, `evt_overflow` ← 1. A bit may then be set in both `evt_rise` and `evt_fall`.
- Acceptance without a new change: `evt_valid` ← 0; masks and `evt_overflow` cleared.
- Upper readdata bits `[31:SW_WIDTH]` are ignored.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Tick counter, candidate and `stable_cnt` all 0.
- Reset mid-operation: any state returns to IDLE on the next edge, and any pending event is dropped.
- Poll tick asserts for one cycle every POLL_DIV cycles. The first tick comes POLL_DIV cycles after reset deassertion.
- Read timing: `avm_read` is high in cycle T; readdata is sampled in cycle T+1.
- Latency: `sw_state` and `evt_valid` update on the edge ending the CAPTURE cycle of the STABLE_COUNT-th matching sample.
- Minimum latency from a clean switch change is (STABLE_COUNT−1)·POLL_DIV + 2 cycles after the first poll that sees it.
- Because POLL_DIV ≥ 4, a tick can never arrive outside IDLE.
- `evt_*` outputs are registered and hold stable while `evt_valid`=1 and `evt_ready`=0, except for accumulation as described in Operation.

## Configuration
- `SW_POLL_IRQ_EN` defined:
  - Adds output `irq` (1 bit), registered and equal to `evt_valid`; reset value 0.
  - Adds input `irq_mask` (SW_WIDTH). Only bits set in `irq_mask` can raise an event: `new_rise` and `new_fall` are ANDed with `irq_mask`.
  - `sw_state` still tracks all bits.
- `SW_POLL_IRQ_EN` undefined: neither port exists, and every bit can raise events.

## Structure
- Package `sw_poll_pkg`:
  - FSM state enum (IDLE, READ, CAPTURE).
  - `PIO_DATA_ADDR` = 2'd0.
  - `PIO_READ_LATENCY` = 1.
- Sub-module `sw_poll_timer`: free-running divider with parameter POLL_DIV, synchronous reset, producing the one-cycle `tick`.

## Test plan
- Reset with `avm_readdata`=0x3FF held → all outputs 0, first `avm_read` pulse exactly POLL_DIV cycles after reset release, `avm_address`=0.
- POLL_DIV=8, STABLE_COUNT=4, readdata 0x000→0x005 held → after the 4th matching sample: `sw_state`=0x005, `evt_valid`=1, `evt_rise`=0x005, `evt_fall`=0; `evt_ready`=1 → cleared the next cycle.
- Bounce: samples 0x001, 0x000, 0x001, 0x001, 0x001, 0x001 → exactly one event, `evt_rise`=0x001, raised on the 6th sample.
- `evt_ready`=0; changes 0x000→0x003 then 0x003→0x001 → `evt_rise`=0x003, `evt_fall`=0x002, `evt_overflow`=1, `sw_state`=0x001.
- New change in the same cycle as `evt_ready`=1 → `evt_valid` stays 1, masks show only the new change, `evt_overflow`=0.
- `reset` asserted in CAPTURE with an event pending → next cycle: `evt_valid`=0, `sw_state`=0, `avm_read`=0; with `SW_POLL_IRQ_EN` and `irq_mask`=0x001, a change on bit 1 only → `sw_state` updates and no event is raised.
